// File: rtl/dot_pkg.sv
// Shared types and helpers for the dot-product datapath and its downstream consumers.
package dot_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic {
    S_ACCUM,
    S_SEND
  } argmax_state_t;

  // Maps fp32 bit patterns onto an unsigned total order: -NaN < -Inf < ... < -0 < +0 < ... < +Inf < +NaN.
  function automatic logic [31:0] fp32_key(input fp32_t x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational a > b on fp32 values under the total bit-pattern order of fp32_key.
module fp32_gt
  import dot_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  gt
);

  assign gt = fp32_key(a) > fp32_key(b);

endmodule

// File: rtl/argmax.sv
// Streaming argmax: tracks the running maximum of an fp32 vector and emits the
// zero-based index of its largest element as a one-word packet after TLAST.
module argmax
  import dot_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  // All-ones pattern has key 0, the bottom of the order; the cnt==0 override
  // makes the stored value irrelevant for the first element anyway.
  localparam fp32_t MAX_CLEAR = 32'hFFFF_FFFF;
  localparam logic [IDX_W-1:0] CNT_SAT = {IDX_W{1'b1}};

  argmax_state_t    state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] max_idx_reg, max_idx_next;
  fp32_t            max_val_reg, max_val_next;
  logic [31:0]      out_data_reg, out_data_next;
  logic             in_ready_reg;

  logic             accept;
  logic             data_gt;
  logic             update;

  fp32_gt u_gt (
    .a  (INPUT_AXIS_TDATA),
    .b  (max_val_reg),
    .gt (data_gt)
  );

  // TREADY is only ever high in S_ACCUM, so accept implies the accumulate state.
  assign accept = INPUT_AXIS_TVALID && in_ready_reg;
  assign update = accept && ((cnt_reg == '0) || data_gt);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    max_idx_next  = max_idx_reg;
    max_val_next  = max_val_reg;
    out_data_next = out_data_reg;

    case (state_reg)
      S_ACCUM: begin
        if (update) begin
          max_idx_next = cnt_reg;
          max_val_next = INPUT_AXIS_TDATA;
        end
        if (accept) begin
          if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (INPUT_AXIS_TLAST) begin
            out_data_next              = '0;
            out_data_next[IDX_W-1:0]   = update ? cnt_reg : max_idx_reg;
            cnt_next                   = '0;
            max_val_next               = MAX_CLEAR;
            state_next                 = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (OUTPUT_AXIS_TREADY) begin
          state_next = S_ACCUM;
        end
      end
      default: state_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_ACCUM;
      cnt_reg      <= '0;
      max_idx_reg  <= '0;
      max_val_reg  <= MAX_CLEAR;
      out_data_reg <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      max_idx_reg  <= max_idx_next;
      max_val_reg  <= max_val_next;
      out_data_reg <= out_data_next;
      in_ready_reg <= (state_next == S_ACCUM);
    end
  end

  assign INPUT_AXIS_TREADY  = in_ready_reg;
  assign OUTPUT_AXIS_TDATA  = out_data_reg;
  assign OUTPUT_AXIS_TVALID = (state_reg == S_SEND);
  assign OUTPUT_AXIS_TLAST  = (state_reg == S_SEND);

endmodule

// File: tb/tb_argmax.sv
// Directed and randomized checks of argmax against an ordering model built on
// sign/magnitude comparison of the fp32 bit patterns.
module tb_argmax;

  localparam int IDX_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  argmax #(.IDX_W(IDX_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .INPUT_AXIS_TDATA   (in_data),
    .INPUT_AXIS_TLAST   (in_last),
    .INPUT_AXIS_TVALID  (in_valid),
    .INPUT_AXIS_TREADY  (in_ready),
    .OUTPUT_AXIS_TDATA  (out_data),
    .OUTPUT_AXIS_TLAST  (out_last),
    .OUTPUT_AXIS_TVALID (out_valid),
    .OUTPUT_AXIS_TREADY (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference order: positive beats negative; among positives larger magnitude
  // wins; among negatives smaller magnitude wins. NaNs fall out by magnitude.
  function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic int ref_argmax(input logic [31:0] v[$]);
    int best = 0;
    for (int i = 1; i < v.size(); i++)
      if (ref_gt(v[i], v[best])) best = i;
    return best;
  endfunction

  // Drives one beat at a negedge and returns at the negedge after its handshake.
  task automatic send_beat(input logic [31:0] d, input logic l, input string tag);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beats(input logic [31:0] v[$], input bit with_last,
                            input int gap, input string tag);
    for (int i = 0; i < v.size(); i++) begin
      send_beat(v[i], with_last && (i == v.size() - 1), tag);
      if (i != v.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  // Called at the negedge right after the TLAST handshake. hold>0 means out_ready
  // was low beforehand and stays low for hold cycles of the result.
  task automatic expect_result(input int exp, input int hold, input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_last"}, {31'd0, out_last}, 32'd1);
    check({tag, "_inrdy_busy"}, {31'd0, in_ready}, 32'd0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_data"}, out_data, exp);
      check({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_drop_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_inrdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v[$];
    logic [31:0] pool[4];
    int exp, len, gap, hold;

    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_inrdy", {31'd0, in_ready}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_inrdy", {31'd0, in_ready}, 32'd1);

    v = '{32'h4073_3334, 32'h408C_CCCD, 32'h40A0_0000, 32'h40B3_3334};
    send_beats(v, 1, 0, "ramp");
    expect_result(3, 0, "ramp");

    v = '{32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000};
    send_beats(v, 1, 0, "neg");
    expect_result(1, 0, "neg");

    v = '{32'h40E0_0000};
    send_beats(v, 1, 0, "single");
    expect_result(0, 0, "single");

    v = '{32'h4000_0000, 32'h4000_0000, 32'h3F80_0000};
    send_beats(v, 1, 0, "tie");
    expect_result(0, 0, "tie");

    v = '{32'h8000_0000, 32'h0000_0000};
    send_beats(v, 1, 0, "szero");
    expect_result(1, 0, "szero");

    out_ready = 1'b0;
    v = '{32'h3DCC_CCCD, 32'h3E99_999A, 32'h3E4C_CCCD};
    send_beats(v, 1, 0, "bp");
    expect_result(1, 6, "bp");

    v = '{32'h4110_0000, 32'h4100_0000};
    send_beats(v, 0, 0, "midrst");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_inrdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_inrdy_back", {31'd0, in_ready}, 32'd1);
    check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    v = '{32'h3F80_0000, 32'h3F00_0000};
    send_beats(v, 1, 0, "after_rst");
    expect_result(0, 0, "after_rst");

    v = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
    send_beats(v, 1, 3, "gaps");
    expect_result(1, 0, "gaps");

    for (int t = 0; t < 25; t++) begin
      pool = '{$urandom, $urandom, 32'h0000_0000, 32'h8000_0000};
      len  = $urandom_range(1, 12);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      v.delete();
      for (int i = 0; i < len; i++)
        v.push_back(($urandom_range(0, 1) == 1) ? $urandom : pool[$urandom_range(0, 3)]);
      exp = ref_argmax(v);
      out_ready = (hold == 0);
      send_beats(v, 1, gap, $sformatf("rnd%0d", t));
      expect_result(exp, hold, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
